mx_block_encoder: RTL and testbench

//  Converts a stream of FP32 values into one OCP MX block (E8M0 shared scale plus

---
 rtl/mx_block_encoder_if.sv | 24 ++
 rtl/mx_block_encoder.sv | 130 +++++++++++++
 tb/tb_mx_block_encoder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mx_block_encoder_if.sv
// Handshake bundle between an FP32 producer and the MX block encoder.
// Input stream plus packed MXFP8 block output.
interface mx_block_encoder_if #(
  parameter int BLOCK_SIZE = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [7:0]              out_scale;
  logic [BLOCK_SIZE*8-1:0] out_elems;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_scale, out_elems
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_scale, out_elems
  );
endinterface

// File: rtl/mx_block_encoder.sv
// Serial FP32 -> OCP MX (E8M0 scale + E4M3 elements) block encoder.
// Fills a block, derives the shared scale, quantizes one slot per cycle.
module mx_block_encoder #(
  parameter int BLOCK_SIZE = 32
) (
  input  logic clk,
  input  logic rst_n,
  mx_block_encoder_if.slave bus
);
  localparam int AW = $clog2(BLOCK_SIZE);
  localparam logic [AW-1:0] LAST = AW'(BLOCK_SIZE - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] SCALE = 2'd1;
  localparam logic [1:0] QUANT = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [AW-1:0]           count_q;
  logic [AW-1:0]           qidx_q;
  logic [7:0]              max_q;
  logic                    nan_q;
  logic [7:0]              scale_q;
  logic [BLOCK_SIZE*8-1:0] elems_q;
  logic [31:0]             buf_q [BLOCK_SIZE];

  logic        xfer;
  logic [31:0] cur;
  logic [7:0]  q_elem;

  function automatic logic [7:0] quant(
    input logic [31:0] x,
    input logic [7:0]  sc
  );
    logic              s;
    logic [7:0]        ex;
    logic [22:0]       m;
    logic signed [9:0] e;
    logic signed [9:0] ef;
    logic              up;
    logic [3:0]        mt;
    logic [1:0]        k;
    logic [26:0]       t;
    logic [3:0]        r;
    s  = x[31];
    ex = x[30:23];
    m  = x[22:0];
    e  = $signed({2'b00, ex}) - $signed({2'b00, sc});
    ef = e + 10'sd7;
    up = m[19] & ((|m[18:0]) | m[20]);
    mt = {1'b0, m[22:20]} + {3'b000, up};
    if (mt[3]) ef = ef + 10'sd1;
    // Subnormal path: shift by 21..24 expressed as 0..3 past bit 21
    k = 2'b01 - e[1:0];
    t = {1'b1, m, 3'b000} >> k;
    r = {1'b0, t[26:24]}
      + {3'b000, t[23] & ((|t[22:0]) | t[24])};
    quant = {s, 7'h00};
    if (ex == 8'h00) begin
      quant = {s, 7'h00};
    end else if (e >= -10'sd6) begin
      if (ef > 10'sd15 || (ef == 10'sd15 && mt[2:0] == 3'b111))
        quant = {s, 7'h7E};
      else
        quant = {s, ef[3:0], mt[2:0]};
    end else if (e >= -10'sd10) begin
      quant = {s, 3'b000, r};
    end
  endfunction

  assign xfer = bus.in_valid && (state_q == FILL);
  assign cur = (qidx_q > count_q) ? 32'h0 : buf_q[qidx_q];
  assign q_elem = nan_q ? 8'h00 : quant(cur, scale_q);

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_scale = scale_q;
  assign bus.out_elems = elems_q;

  // Next-state selection for the fill/scale/quantize/output sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:  if (xfer && (count_q == LAST || bus.in_last)) state_d = SCALE;
      SCALE: state_d = QUANT;
      QUANT: if (qidx_q == LAST) state_d = OUT;
      OUT:   if (bus.out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State, block statistics, element buffer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      qidx_q  <= '0;
      max_q   <= 8'h00;
      nan_q   <= 1'b0;
      scale_q <= 8'h00;
      elems_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) buf_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        FILL: if (xfer) begin
          buf_q[count_q] <= bus.in_data;
          if (bus.in_data[30:23] == 8'hFF) nan_q <= 1'b1;
          else if (bus.in_data[30:23] > max_q) max_q <= bus.in_data[30:23];
          if (!(count_q == LAST || bus.in_last)) count_q <= count_q + 1'b1;
        end
        SCALE: begin
          qidx_q  <= '0;
          scale_q <= nan_q ? 8'hFF
                   : (max_q < 8'd8 ? 8'h00 : max_q - 8'd8);
        end
        QUANT: begin
          elems_q[{qidx_q, 3'b000} +: 8] <= q_elem;
          qidx_q <= qidx_q + 1'b1;
        end
        OUT: if (bus.out_ready) begin
          count_q <= '0;
          max_q   <= 8'h00;
          nan_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mx_block_encoder.sv
// Directed bench for mx_block_encoder (BLOCK_SIZE = 32).
// Each scenario task drives a block and checks its own expectations.
module tb_mx_block_encoder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mx_block_encoder_if #(.BLOCK_SIZE(32)) itf ();

  mx_block_encoder #(.BLOCK_SIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (itf.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] stim [32];
  logic [7:0]  expd [32];

  task automatic send(input logic [31:0] d, input bit last);
    itf.in_valid = 1'b1;
    itf.in_data  = d;
    itf.in_last  = last;
    @(posedge clk); #1;
    itf.in_valid = 1'b0;
    itf.in_last  = 1'b0;
  endtask

  task automatic send_block(input int n, input bit last);
    for (int i = 0; i < n; i++) send(stim[i], last && (i == n - 1));
  endtask

  task automatic wait_out(output int cyc, output bit to);
    cyc = 1;
    to  = 1'b0;
    while (!itf.out_valid && !to) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) to = 1'b1;
    end
  endtask

  task automatic accept();
    itf.out_ready = 1'b1;
    @(posedge clk); #1;
    itf.out_ready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] d, input logic [7:0] q);
    for (int i = 0; i < 32; i++) begin
      stim[i] = d;
      expd[i] = q;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (itf.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", itf.in_ready);
    end
    n_cmp++;
    if (itf.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", itf.out_valid);
    end
    n_cmp++;
    if (itf.out_scale !== 8'h00) begin
      n_bad++; $display("FAIL reset_scale: got %h want 00", itf.out_scale);
    end
    n_cmp++;
    if (itf.out_elems !== '0) begin
      n_bad++; $display("FAIL reset_elems: got %h want 0", itf.out_elems);
    end
  endtask

  task automatic test_ones();
    int cyc; bit to;
    fill(32'h3F800000, 8'h78);
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL ones_timeout: got none want out_valid"); end
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL ones_latency: got %0d want 34", cyc); end
    n_cmp++;
    if (itf.out_scale !== 8'h77) begin
      n_bad++; $display("FAIL ones_scale: got %h want 77", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL ones_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_rne();
    int cyc; bit to;
    fill(32'h3F800000, 8'h70);
    stim[0] = 32'h40000000; expd[0] = 8'h78;
    stim[1] = 32'h3F880000; expd[1] = 8'h70;
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rne_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h78) begin
      n_bad++; $display("FAIL rne_scale: got %h want 78", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL rne_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_early_close();
    int cyc; bit to;
    fill(32'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stim[i] = 32'hBF800000; expd[i] = 8'hF8;
    end
    send_block(3, 1'b1);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL early_timeout: got none want out_valid"); end
    n_cmp++;
    if (cyc !== 34) begin n_bad++; $display("FAIL early_latency: got %0d want 34", cyc); end
    n_cmp++;
    if (itf.out_scale !== 8'h77) begin
      n_bad++; $display("FAIL early_scale: got %h want 77", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL early_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_nan();
    int cyc; bit to;
    fill(32'h3F800000, 8'h00);
    stim[5] = 32'h7FC00000;
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL nan_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'hFF) begin
      n_bad++; $display("FAIL nan_scale: got %h want ff", itf.out_scale);
    end
    n_cmp++;
    if (itf.out_elems !== '0) begin
      n_bad++; $display("FAIL nan_elems: got %h want 0", itf.out_elems);
    end
    accept();
  endtask

  task automatic test_zero_underflow();
    int cyc; bit to;
    fill(32'h0, 8'h00);
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL zero_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h00) begin
      n_bad++; $display("FAIL zero_scale: got %h want 00", itf.out_scale);
    end
    n_cmp++;
    if (itf.out_elems !== '0) begin
      n_bad++; $display("FAIL zero_elems: got %h want 0", itf.out_elems);
    end
    accept();
    stim[0] = 32'h49742400; expd[0] = 8'h7E;
    stim[1] = 32'h358637BD; expd[1] = 8'h00;
    send_block(2, 1'b1);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL uflow_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h8A) begin
      n_bad++; $display("FAIL uflow_scale: got %h want 8a", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL uflow_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_subnormal();
    int cyc; bit to;
    fill(32'h0, 8'h00);
    stim[0] = 32'h3F800000; expd[0] = 8'h78;
    stim[1] = 32'h38000000; expd[1] = 8'h04;
    stim[2] = 32'h38400000; expd[2] = 8'h06;
    stim[3] = 32'h387FFFFF; expd[3] = 8'h08;
    stim[4] = 32'h38800000; expd[4] = 8'h08;
    stim[5] = 32'hB8400000; expd[5] = 8'h86;
    stim[6] = 32'h36800000; expd[6] = 8'h00;
    stim[7] = 32'h36C00000; expd[7] = 8'h01;
    stim[8] = 32'h00000001; expd[8] = 8'h00;
    stim[9] = 32'h80000000; expd[9] = 8'h80;
    send_block(10, 1'b1);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL sub_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h77) begin
      n_bad++; $display("FAIL sub_scale: got %h want 77", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL sub_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_back_pressure();
    int cyc; bit to;
    fill(32'h3F800000, 8'h78);
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bp_timeout: got none want out_valid"); end
    for (int c = 0; c < 5; c++) begin
      itf.in_valid = 1'b1;
      itf.in_data  = 32'h7F7FFFFF;
      @(posedge clk); #1;
      n_cmp++;
      if (itf.out_valid !== 1'b1 || itf.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got valid %b ready %b want 1 0", c, itf.out_valid, itf.in_ready);
      end
      n_cmp++;
      if (itf.out_scale !== 8'h77 || itf.out_elems !== {32{8'h78}}) begin
        n_bad++;
        $display("FAIL bp_stable%0d: got scale %h want 77", c, itf.out_scale);
      end
    end
    itf.in_valid = 1'b0;
    accept();
    n_cmp++;
    if (itf.in_ready !== 1'b1 || itf.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got ready %b valid %b want 1 0", itf.in_ready, itf.out_valid);
    end
    fill(32'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stim[i] = 32'h3F800000; expd[i] = 8'h78;
    end
    send_block(3, 1'b1);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL bp2_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h77) begin
      n_bad++; $display("FAIL bp2_scale: got %h want 77", itf.out_scale);
    end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (itf.out_elems[8*i +: 8] !== expd[i]) begin
        n_bad++;
        $display("FAIL bp2_el%0d: got %h want %h", i, itf.out_elems[8*i +: 8], expd[i]);
      end
    end
    accept();
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; bit seen;
    fill(32'h40000000, 8'h78);
    send_block(5, 1'b0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (itf.out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rmid_no_out: got out_valid want none"); end
    fill(32'h3F800000, 8'h78);
    send_block(32, 1'b0);
    wait_out(cyc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL rmid_timeout: got none want out_valid"); end
    n_cmp++;
    if (itf.out_scale !== 8'h77) begin
      n_bad++; $display("FAIL rmid_scale: got %h want 77", itf.out_scale);
    end
    n_cmp++;
    if (itf.out_elems !== {32{8'h78}}) begin
      n_bad++; $display("FAIL rmid_elems: got %h want all 78", itf.out_elems);
    end
    accept();
  endtask

  initial begin
    rst_n         = 1'b0;
    itf.in_valid  = 1'b0;
    itf.in_data   = 32'h0;
    itf.in_last   = 1'b0;
    itf.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_ones();
    test_rne();
    test_early_close();
    test_nan();
    test_zero_underflow();
    test_subnormal();
    test_back_pressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
